// File: rtl/arb_grant_mux.sv
// Steers the arbiter-granted requester's beats into one registered valid/ready channel,
// holding the source until the packet's last beat has been accepted.
module arb_grant_mux #(
  parameter int NUM_REQ = 16,
  parameter int DATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_REQ)-1:0]   out_src,
  output logic                         out_last,
  output logic                         locked,
  output logic                         grant_err
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_lock_src, w_lock_src_nxt;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_last;
  logic               r_grant_err;

  logic [SRC_W-1:0]   w_gidx;
  logic [SRC_W-1:0]   w_sel;
  logic               w_grant_multi;
  logic               w_grant_onehot;
  logic               w_cand;
  logic               w_slot_free;
  logic               w_take;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_last;

  // A grant is one-hot exactly when it is non-zero and clearing its lowest bit leaves nothing.
  assign w_grant_multi  = (grant & (grant - NUM_REQ'(1))) != '0;
  assign w_grant_onehot = (grant != '0) && !w_grant_multi;

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) w_gidx = w_gidx | SRC_W'(i);
    end
  end

  always_comb begin
    w_sel  = w_gidx;
    w_cand = w_grant_onehot && req[w_gidx];
    if (r_state == LOCKED) begin
      w_sel  = r_lock_src;
      w_cand = req[r_lock_src];
    end
  end

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_take      = w_cand && w_slot_free && !rst;
  assign w_sel_data  = req_data[w_sel*DATA_W +: DATA_W];
  assign w_sel_last  = req_last[w_sel];
  assign req_ack     = w_take ? (NUM_REQ'(1) << w_sel) : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_src_nxt = r_lock_src;
    if (w_take) begin
      if (w_sel_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt    = LOCKED;
        w_lock_src_nxt = w_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lock_src  <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_src <= w_lock_src_nxt;
      if (r_state == IDLE && w_grant_multi) r_grant_err <= 1'b1;
    end
  end

  // Output register stage: loads on accept, otherwise drains on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_sel;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;
  assign locked    = (r_state == LOCKED);
  assign grant_err = r_grant_err;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Directed bench for arb_grant_mux: single beat, locked packet, backpressure, bubbles,
// bad grant and reset mid-packet, each against hand-computed values.
module tb_arb_grant_mux;

  localparam int NUM_REQ = 16;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [3:0]                out_src;
  logic                      out_last;
  logic                      locked;
  logic                      grant_err;

  int checks   = 0;
  int failures = 0;

  arb_grant_mux #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .req_ack(req_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_last(out_last), .locked(locked),
    .grant_err(grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int idx, input logic [DATA_W-1:0] d, input logic last);
    req_data[idx*DATA_W +: DATA_W] = d;
    req_last[idx] = last;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_last = '0; grant = '0; out_ready = 1'b1;
    // Reset state, with a request pending that must not be acknowledged.
    req = 16'h0004; grant = 16'h0004; beat(2, 32'hA5A5A5A5, 1'b1);
    tick(); tick();
    chk("rst_ack", req_ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_last", out_last, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", grant_err, 0);

    // Single-beat packet from src 2.
    rst = 1'b0; #1;
    chk("t1_ack", req_ack, 16'h0004);
    tick();
    req = '0; grant = '0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hA5A5A5A5);
    chk("t1_src", out_src, 2);
    chk("t1_last", out_last, 1);
    chk("t1_locked", locked, 0);

    // Three-beat packet from src 5; grant moves to src 9 after the first beat.
    req = 16'h0020; grant = 16'h0020; beat(5, 32'h11, 1'b0); #1;
    chk("t2_ack0", req_ack, 16'h0020);
    tick();
    chk("t2_data0", out_data, 32'h11);
    chk("t2_lock0", locked, 1);
    req = 16'h0220; grant = 16'h0200; beat(5, 32'h22, 1'b0); beat(9, 32'h99, 1'b1); #1;
    chk("t2_ack1", req_ack, 16'h0020);
    tick();
    chk("t2_data1", out_data, 32'h22);
    chk("t2_src1", out_src, 5);
    chk("t2_lock1", locked, 1);
    beat(5, 32'h33, 1'b1); #1;
    chk("t2_ack2", req_ack, 16'h0020);
    tick();
    chk("t2_data2", out_data, 32'h33);
    chk("t2_src2", out_src, 5);
    chk("t2_last2", out_last, 1);
    chk("t2_lock2", locked, 0);
    req = 16'h0200; #1;
    chk("t2_ack9", req_ack, 16'h0200);
    tick();
    chk("t2_src9", out_src, 9);
    chk("t2_data9", out_data, 32'h99);

    // Backpressure: held output, then same-cycle drain and take.
    out_ready = 1'b0; req = 16'h0040; grant = 16'h0040; beat(6, 32'h66, 1'b1); #1;
    chk("t3_ack_bp", req_ack, 0);
    tick();
    chk("t3_valid_bp", out_valid, 1);
    chk("t3_data_bp", out_data, 32'h99);
    chk("t3_src_bp", out_src, 9);
    out_ready = 1'b1; #1;
    chk("t3_ack_go", req_ack, 16'h0040);
    tick();
    chk("t3_valid_go", out_valid, 1);
    chk("t3_data_go", out_data, 32'h66);
    chk("t3_src_go", out_src, 6);

    // Bubble while locked to src 3; src 8 holds the grant but must wait.
    req = 16'h0008; grant = 16'h0008; beat(3, 32'h31, 1'b0); #1;
    chk("t4_ack0", req_ack, 16'h0008);
    tick();
    chk("t4_lock0", locked, 1);
    req = 16'h0100; grant = 16'h0100; beat(8, 32'h88, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_ack_bub", req_ack, 0);
      tick();
      chk("t4_valid_bub", out_valid, 0);
      chk("t4_lock_bub", locked, 1);
    end
    req = 16'h0108; beat(3, 32'h32, 1'b1); #1;
    chk("t4_ack_res", req_ack, 16'h0008);
    tick();
    chk("t4_data_res", out_data, 32'h32);
    chk("t4_src_res", out_src, 3);
    chk("t4_lock_res", locked, 0);
    req = 16'h0100; #1;
    chk("t4_ack8", req_ack, 16'h0100);
    tick();
    chk("t4_src8", out_src, 8);

    // Bad grant in IDLE, then a stale grant; the error is sticky.
    req = 16'h0011; grant = 16'h0011; #1;
    chk("t5_ack_bad", req_ack, 0);
    tick();
    chk("t5_err", grant_err, 1);
    chk("t5_valid", out_valid, 0);
    req = 16'h0000; grant = 16'h0002; #1;
    chk("t5_ack_stale", req_ack, 0);
    tick();
    chk("t5_err_hold", grant_err, 1);
    chk("t5_valid_stale", out_valid, 0);
    grant = '0;
    tick();
    chk("t5_err_hold2", grant_err, 1);

    // Reset during the second beat of a four-beat packet from src 4.
    req = 16'h0010; grant = 16'h0010; beat(4, 32'h41, 1'b0); #1;
    chk("t6_ack0", req_ack, 16'h0010);
    tick();
    chk("t6_lock0", locked, 1);
    beat(4, 32'h42, 1'b0); rst = 1'b1; #1;
    chk("t6_ack_rst", req_ack, 0);
    tick();
    chk("t6_valid_rst", out_valid, 0);
    chk("t6_lock_rst", locked, 0);
    chk("t6_err_rst", grant_err, 0);
    rst = 1'b0; req = 16'h0001; grant = 16'h0001; beat(0, 32'h0D, 1'b1); #1;
    chk("t6_ack_new", req_ack, 16'h0001);
    tick();
    req = '0; grant = '0;
    chk("t6_valid_new", out_valid, 1);
    chk("t6_data_new", out_data, 32'h0D);
    chk("t6_src_new", out_src, 0);
    chk("t6_last_new", out_last, 1);
    chk("t6_lock_new", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
